// File: rtl/inpref_skew_feeder.sv
// Input prefetch tile buffer: captures one DEPTH x ROWS tile from the loader, then replays it
// column by column in the selected order, skewing row r by r cycles for the systolic array.
//
// state  | meaning
// LOAD   | accepting loader columns into the tile RAM
// READY  | tile complete, waiting for the first in_en (mode latched there)
// STREAM | issuing one column per in_en cycle
// DRAIN  | no more issues, skew pipeline emptying until tile_done
module inpref_skew_feeder #(
   parameter int DATA_W = 8,
   parameter int ROWS   = 3,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     inpref_rst_n,
   input  logic [1:0]               inpref_mode_selector,
   input  logic                     in_en,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [ROWS*DATA_W-1:0]   wr_data,
   output logic [ROWS*DATA_W-1:0]   row_data,
   output logic [ROWS-1:0]          row_valid,
   output logic                     tile_done
);

   localparam int CW = $clog2(DEPTH);
   localparam int IW = CW + 1;
   localparam logic [CW-1:0] LAST_PTR = CW'(DEPTH - 1);
   localparam logic [IW-1:0] DEPTH_I  = IW'(DEPTH);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_READY  = 2'd1,
      ST_STREAM = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          wr_ptr_q;
   logic [IW-1:0]          rd_idx_q;
   logic [IW-1:0]          issue_cnt_q;
   logic [1:0]             mode_q;
   logic [ROWS*DATA_W-1:0] tile_mem [DEPTH];

   logic [1:0]             sel_mode;
   logic [IW-1:0]          start_idx;
   logic [IW-1:0]          step;
   logic [IW-1:0]          n_issue;
   logic [IW-1:0]          cnt_eff;
   logic [IW-1:0]          issue_idx;
   logic                   wr_fire;
   logic                   issue;
   logic                   issue_last;
   logic [ROWS*DATA_W-1:0] issue_col;

   logic [ROWS-1:0]        sk_valid_q;
   logic [ROWS-1:0]        sk_last_q;

   assign tile_done = sk_valid_q[ROWS-1] & sk_last_q[ROWS-1];
   assign row_valid = sk_valid_q;

   // In READY the live selector defines the sequence; afterwards only the latched copy counts.
   always_comb begin
      state_d    = state_q;
      sel_mode   = (state_q == ST_READY) ? inpref_mode_selector : mode_q;
      start_idx  = {{(IW-1){1'b0}}, sel_mode[1]};
      step       = sel_mode[0] ? IW'(1) : IW'(2);
      n_issue    = sel_mode[0] ? (DEPTH_I - start_idx)
                               : ((DEPTH_I - start_idx + IW'(1)) >> 1);
      cnt_eff    = (state_q == ST_READY) ? '0 : issue_cnt_q;
      issue_idx  = (state_q == ST_READY) ? start_idx : rd_idx_q;
      wr_ready   = (state_q == ST_LOAD);
      wr_fire    = wr_valid & wr_ready;
      issue      = in_en & ((state_q == ST_READY) | (state_q == ST_STREAM));
      issue_last = issue & (cnt_eff == (n_issue - IW'(1)));
      issue_col  = tile_mem[issue_idx[CW-1:0]];

      case (state_q)
         ST_LOAD:   if (wr_fire && (wr_ptr_q == LAST_PTR)) state_d = ST_READY;
         ST_READY:  if (issue) state_d = ST_STREAM;
         ST_STREAM: state_d = ST_STREAM;
         ST_DRAIN:  if (tile_done) state_d = ST_LOAD;
         default:   state_d = ST_LOAD;
      endcase
      if (issue_last) state_d = ST_DRAIN;
   end

   always_ff @(posedge clk) begin
      if (!inpref_rst_n) begin
         state_q     <= ST_LOAD;
         wr_ptr_q    <= '0;
         rd_idx_q    <= '0;
         issue_cnt_q <= '0;
         mode_q      <= '0;
         sk_valid_q  <= '0;
         sk_last_q   <= '0;
      end else begin
         state_q <= state_d;
         if (wr_fire) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + CW'(1);
         if (issue) begin
            mode_q      <= sel_mode;
            rd_idx_q    <= issue_idx + step;
            issue_cnt_q <= cnt_eff + IW'(1);
         end
         sk_valid_q[0] <= issue;
         sk_last_q[0]  <= issue_last;
         for (int k = 1; k < ROWS; k++) begin
            sk_valid_q[k] <= sk_valid_q[k-1];
            sk_last_q[k]  <= sk_last_q[k-1];
         end
      end
   end

   // Tile RAM keeps its contents across reset; only the write itself is blocked.
   always_ff @(posedge clk) begin
      if (inpref_rst_n && wr_fire) tile_mem[wr_ptr_q] <= wr_data;
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [DATA_W-1:0] pipe_q [r+1];

      always_ff @(posedge clk) begin
         if (!inpref_rst_n) begin
            for (int k = 0; k <= r; k++) pipe_q[k] <= '0;
         end else begin
            pipe_q[0] <= issue_col[r*DATA_W +: DATA_W];
            for (int k = 1; k <= r; k++) pipe_q[k] <= pipe_q[k-1];
         end
      end

      assign row_data[r*DATA_W +: DATA_W] = sk_valid_q[r] ? pipe_q[r] : '0;
   end

endmodule

// File: tb/tb_inpref_skew_feeder.sv
// Directed bench for inpref_skew_feeder: hand-written issue schedules per mode, with expected
// row outputs derived as "row r in cycle k shows the column issued in cycle k-1-r".
module tb_inpref_skew_feeder;

   localparam int DATA_W = 8;
   localparam int ROWS   = 3;
   localparam int DEPTH  = 8;

   logic                   clk = 1'b0;
   logic                   inpref_rst_n;
   logic [1:0]             inpref_mode_selector;
   logic                   in_en;
   logic                   wr_valid;
   logic                   wr_ready;
   logic [ROWS*DATA_W-1:0] wr_data;
   logic [ROWS*DATA_W-1:0] row_data;
   logic [ROWS-1:0]        row_valid;
   logic                   tile_done;

   int checks   = 0;
   int failures = 0;

   int          exp_issue [32];
   logic [31:0] en_pat;
   int          dofs;

   always #5 clk = ~clk;

   inpref_skew_feeder #(.DATA_W(DATA_W), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
      .clk                  (clk),
      .inpref_rst_n         (inpref_rst_n),
      .inpref_mode_selector (inpref_mode_selector),
      .in_en                (in_en),
      .wr_valid             (wr_valid),
      .wr_ready             (wr_ready),
      .wr_data              (wr_data),
      .row_data             (row_data),
      .row_valid            (row_valid),
      .tile_done            (tile_done)
   );

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_sched();
      for (int i = 0; i < 32; i++) exp_issue[i] = -1;
      en_pat = '0;
   endtask

   task automatic load_tile(input int ofs, input bit en_last, input bit hold);
      for (int c = 0; c < DEPTH; c++) begin
         wr_valid = 1'b1;
         for (int r = 0; r < ROWS; r++) wr_data[r*DATA_W +: DATA_W] = 8'(16*c + r + ofs);
         in_en = (c == DEPTH-1) ? en_last : 1'b0;
         chk($sformatf("load_wr_ready_c%0d", c), {31'd0, wr_ready}, 32'd1);
         @(posedge clk); #1;
      end
      in_en = 1'b0;
      if (hold) begin
         wr_valid = 1'b1;
         wr_data  = {ROWS{8'hEE}};
      end else begin
         wr_valid = 1'b0;
      end
   endtask

   task automatic run_stream(input logic [1:0] mode, input int ncyc, input string name);
      bit         done_seen;
      bit         exp_done;
      bit         ev;
      logic [7:0] ed;
      int         j;
      int         last_col;
      done_seen = 1'b0;
      last_col  = -1;
      for (int i = 0; i < 32; i++) if (exp_issue[i] > last_col) last_col = exp_issue[i];
      inpref_mode_selector = mode;
      in_en = en_pat[0];
      for (int k = 1; k <= ncyc; k++) begin
         @(posedge clk); #1;
         // a mid-tile mode change must not alter the sequence
         inpref_mode_selector = mode ^ 2'b01;
         exp_done = 1'b0;
         for (int r = 0; r < ROWS; r++) begin
            j  = k - 1 - r;
            ev = 1'b0;
            ed = 8'h00;
            if (j >= 0 && j < 32) begin
               if (exp_issue[j] >= 0) begin
                  ev = 1'b1;
                  ed = 8'(16*exp_issue[j] + r + dofs);
                  if (r == ROWS-1 && exp_issue[j] == last_col) exp_done = 1'b1;
               end
            end
            chk($sformatf("%s_c%0d_valid%0d", name, k, r), {31'd0, row_valid[r]}, {31'd0, ev});
            chk($sformatf("%s_c%0d_data%0d", name, k, r),
                {24'd0, row_data[r*DATA_W +: DATA_W]}, {24'd0, ed});
         end
         chk($sformatf("%s_c%0d_tile_done", name, k), {31'd0, tile_done}, {31'd0, exp_done});
         chk($sformatf("%s_c%0d_wr_ready", name, k), {31'd0, wr_ready}, {31'd0, done_seen});
         if (exp_done) done_seen = 1'b1;
         in_en = (k < 32) ? en_pat[k] : 1'b0;
      end
      in_en    = 1'b0;
      wr_valid = 1'b0;
   endtask

   initial begin
      inpref_rst_n         = 1'b0;
      inpref_mode_selector = 2'b00;
      in_en                = 1'b0;
      wr_valid             = 1'b0;
      wr_data              = '0;
      dofs                 = 0;
      clear_sched();

      repeat (2) @(posedge clk);
      #1;
      chk("reset_row_valid", {29'd0, row_valid}, 32'd0);
      chk("reset_row_data", {8'd0, row_data}, 32'd0);
      chk("reset_tile_done", {31'd0, tile_done}, 32'd0);
      chk("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
      inpref_rst_n = 1'b1;

      // 1: mode 01, full sequence; in_en on the last write must be ignored
      load_tile(0, 1'b1, 1'b0);
      clear_sched();
      en_pat = 32'h0000_00FF;
      for (int i = 0; i < 8; i++) exp_issue[i] = i;
      run_stream(2'b01, 11, "t1");

      // 2: mode 10, odd columns only
      load_tile(0, 1'b0, 1'b0);
      clear_sched();
      en_pat = 32'h0000_000F;
      exp_issue[0] = 1; exp_issue[1] = 3; exp_issue[2] = 5; exp_issue[3] = 7;
      run_stream(2'b10, 7, "t2");

      // 3: mode 11 with a bubble in cycle 2
      load_tile(0, 1'b0, 1'b0);
      clear_sched();
      en_pat = 32'h0000_00FB;
      exp_issue[0] = 1; exp_issue[1] = 2; exp_issue[3] = 3; exp_issue[4] = 4;
      exp_issue[5] = 5; exp_issue[6] = 6; exp_issue[7] = 7;
      run_stream(2'b11, 11, "t3");

      // 4: wr_valid held high with a ninth column through READY/STREAM/DRAIN
      load_tile(0, 1'b0, 1'b1);
      clear_sched();
      en_pat = 32'h0000_00FF;
      for (int i = 0; i < 8; i++) exp_issue[i] = i;
      run_stream(2'b01, 11, "t4");

      // 5: reset after three issues, then a fresh tile
      load_tile(0, 1'b0, 1'b0);
      inpref_mode_selector = 2'b01;
      in_en = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      inpref_rst_n = 1'b0;
      @(posedge clk); #1;
      chk("t5_rst_row_valid", {29'd0, row_valid}, 32'd0);
      chk("t5_rst_row_data", {8'd0, row_data}, 32'd0);
      chk("t5_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("t5_rst_tile_done", {31'd0, tile_done}, 32'd0);
      inpref_rst_n = 1'b1;
      in_en = 1'b0;
      load_tile(8, 1'b0, 1'b0);
      dofs = 8;
      clear_sched();
      en_pat = 32'h0000_00FF;
      for (int i = 0; i < 8; i++) exp_issue[i] = i;
      run_stream(2'b01, 11, "t5");
      dofs = 0;

      // 6: mode 00 with in_en held for 12 cycles
      load_tile(0, 1'b0, 1'b0);
      clear_sched();
      en_pat = 32'h0000_0FFF;
      exp_issue[0] = 0; exp_issue[1] = 2; exp_issue[2] = 4; exp_issue[3] = 6;
      run_stream(2'b00, 13, "t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
